// File: rtl/axi_reg_pkg.sv
// Shared definitions for the AXI4-Lite register slave: register map, response codes, FSM states.
package axi_reg_pkg;

    localparam logic [7:0] REG_CONTROL    = 8'h00;
    localparam logic [7:0] REG_STATUS     = 8'h04;
    localparam logic [7:0] REG_IRQ_STATUS = 8'h08;
    localparam logic [7:0] REG_IRQ_ENABLE = 8'h0C;
    localparam logic [7:0] REG_SCRATCH0   = 8'h10;
    localparam logic [7:0] REG_SCRATCH1   = 8'h14;
    localparam logic [7:0] REG_SCRATCH2   = 8'h18;
    localparam logic [7:0] REG_SCRATCH3   = 8'h1C;
    localparam logic [7:0] REG_VERSION    = 8'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

    // Every word-aligned offset from CONTROL up to VERSION is mapped.
    function automatic logic addr_valid(input logic [7:0] off);
        return (off[1:0] == 2'b00) && (off <= REG_VERSION);
    endfunction

    // Merge new_val into old_val byte by byte under the write strobes.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle between the UART bridge master and register slaves.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register block: CONTROL, STATUS, IRQ status/enable, four scratch words, VERSION.
// Write and read channels are independent two-state FSMs.
module axi_lite_reg_slave
    import axi_reg_pkg::*;
#(
    parameter logic [31:0] VERSION    = 32'h0001_0000,
    parameter int unsigned IRQ_WIDTH  = 8,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4_lite_if.slave           axi,
    input  logic [31:0]          status_in,
    input  logic [IRQ_WIDTH-1:0] irq_event,
    output logic [31:0]          ctrl_out,
    output logic                 ctrl_wr_pulse,
    output logic                 irq_out
);

    wr_state_t wr_state_q, wr_state_d;
    logic       aw_held_q, aw_held_d;
    logic [7:0] awaddr_q, awaddr_d;
    logic       w_held_q, w_held_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0] wstrb_q, wstrb_d;
    logic       bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;
    logic       awready, wready, wr_commit, wr_ok;

    rd_state_t rd_state_q, rd_state_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        arready;
    logic [31:0] rd_word;

    logic [31:0]          ctrl_q, ctrl_d;
    logic [IRQ_WIDTH-1:0] irq_status_q, irq_status_d;
    logic [IRQ_WIDTH-1:0] irq_enable_q, irq_enable_d;
    logic [IRQ_WIDTH-1:0] irq_clr;
    logic [31:0]          scratch_q [4];
    logic [31:0]          scratch_d [4];
    logic                 ctrl_wr_pulse_q, ctrl_wr_pulse_d;
    logic                 irq_out_q, irq_out_d;

    // Upper address bits are decoded by the interconnect.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.awaddr[31:8], axi.araddr[31:8]};

    // Write FSM: collect AW and W in any order, commit once both are held, then hold B.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awready    = 1'b0;
        wready     = 1'b0;
        wr_commit  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                awready = !aw_held_q && !rst;
                wready  = !w_held_q && !rst;
                if (axi.awvalid && awready) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = axi.awaddr[7:0];
                end
                if (axi.wvalid && wready) begin
                    w_held_d = 1'b1;
                    wdata_d  = axi.wdata;
                    wstrb_d  = axi.wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    wr_commit  = 1'b1;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = addr_valid(awaddr_d) ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign wr_ok = wr_commit && addr_valid(awaddr_d);

    // Register file next state; IRQ set from events takes priority over a W1C clear.
    always_comb begin
        ctrl_d       = ctrl_q;
        irq_enable_d = irq_enable_q;
        scratch_d    = scratch_q;
        irq_clr      = '0;
        if (wr_ok) begin
            case (awaddr_d)
                REG_CONTROL: ctrl_d = apply_strb(ctrl_q, wdata_d, wstrb_d);
                REG_IRQ_STATUS: begin
                    for (int i = 0; i < IRQ_WIDTH; i++) begin
                        irq_clr[i] = wdata_d[i] & wstrb_d[i/8];
                    end
                end
                REG_IRQ_ENABLE: begin
                    for (int i = 0; i < IRQ_WIDTH; i++) begin
                        if (wstrb_d[i/8]) irq_enable_d[i] = wdata_d[i];
                    end
                end
                REG_SCRATCH0, REG_SCRATCH1, REG_SCRATCH2, REG_SCRATCH3: begin
                    scratch_d[awaddr_d[3:2]] = apply_strb(scratch_q[awaddr_d[3:2]], wdata_d,
                                                          wstrb_d);
                end
                default: ;
            endcase
        end
        irq_status_d    = (irq_status_q & ~irq_clr) | irq_event;
        ctrl_wr_pulse_d = wr_ok && (awaddr_d == REG_CONTROL) && (|wstrb_d);
        irq_out_d       = |(irq_status_q & irq_enable_q);
    end

    // Read data mux over current register values, so a colliding write is not yet visible.
    always_comb begin
        rd_word = '0;
        case (axi.araddr[7:0])
            REG_CONTROL:    rd_word = ctrl_q;
            REG_STATUS:     rd_word = status_in;
            REG_IRQ_STATUS: rd_word[IRQ_WIDTH-1:0] = irq_status_q;
            REG_IRQ_ENABLE: rd_word[IRQ_WIDTH-1:0] = irq_enable_q;
            REG_SCRATCH0:   rd_word = scratch_q[0];
            REG_SCRATCH1:   rd_word = scratch_q[1];
            REG_SCRATCH2:   rd_word = scratch_q[2];
            REG_SCRATCH3:   rd_word = scratch_q[3];
            REG_VERSION:    rd_word = VERSION;
            default:        rd_word = '0;
        endcase
    end

    // Read FSM: accept AR in idle, register the response and hold it until rready.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        arready    = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                arready = !rst;
                if (axi.arvalid && arready) begin
                    rdata_d    = rd_word;
                    rresp_d    = addr_valid(axi.araddr[7:0]) ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (axi.rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q      <= W_IDLE;
            aw_held_q       <= 1'b0;
            awaddr_q        <= '0;
            w_held_q        <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            bvalid_q        <= 1'b0;
            bresp_q         <= '0;
            rd_state_q      <= R_IDLE;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            rresp_q         <= '0;
            ctrl_q          <= CTRL_RESET;
            irq_status_q    <= '0;
            irq_enable_q    <= '0;
            for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
            ctrl_wr_pulse_q <= 1'b0;
            irq_out_q       <= 1'b0;
        end else begin
            wr_state_q      <= wr_state_d;
            aw_held_q       <= aw_held_d;
            awaddr_q        <= awaddr_d;
            w_held_q        <= w_held_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            rd_state_q      <= rd_state_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            rresp_q         <= rresp_d;
            ctrl_q          <= ctrl_d;
            irq_status_q    <= irq_status_d;
            irq_enable_q    <= irq_enable_d;
            scratch_q       <= scratch_d;
            ctrl_wr_pulse_q <= ctrl_wr_pulse_d;
            irq_out_q       <= irq_out_d;
        end
    end

    assign axi.awready   = awready;
    assign axi.wready    = wready;
    assign axi.bvalid    = bvalid_q;
    assign axi.bresp     = bresp_q;
    assign axi.arready   = arready;
    assign axi.rvalid    = rvalid_q;
    assign axi.rdata     = rdata_q;
    assign axi.rresp     = rresp_q;
    assign ctrl_out      = ctrl_q;
    assign ctrl_wr_pulse = ctrl_wr_pulse_q;
    assign irq_out       = irq_out_q;

endmodule
